receptor_serial_simbolo: RTL and testbench
==========================================

// Module: receptor_serial_simbolo
// PURPOSE
//  - Serial frame receiver directly upstream of the 7-segment mapping stage.
//  - Deframes an async serial line: start, 5 data bits LSB first, parity, stop.
//  - Checks parity, then presents a held 5-bit symbol and parity-OK flag.
//  - The mapper consumes these: 1 on the flag = parity correct; 0 = show parity-error glyph.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per serial bit; integer >= 4, even
//  PARITY_ODD    0   0 = even parity over data+parity bit; 1 = odd
// PORTS
//  clk        in   1  single system clock, rising edge
//  rst        in   1  synchronous, active-high reset
//  rx         in   1  async serial line, idle high
//  entrada    out  5  last good symbol, held until next good frame
//  erropar    out  1  1 = parity of held symbol correct; 0 = parity error
//  valido     out  1  one-cycle pulse when entrada/erropar update
//  erroquadro out  1  one-cycle pulse on framing error (stop bit = 0)
//  ocupado    out  1  1 while FSM is not in IDLE
// BEHAVIOUR
//  Reset (rst=1 at a clk edge):
//   - entrada=5'b11111 (not a mapped code, so the display is blank); erropar=1
//   - valido=0, erroquadro=0, ocupado=0; FSM=IDLE; counters=0; synchronizer=2'b11
//   - rst mid-frame aborts the frame immediately; no output update from that frame.
//  Input sync: rx passes through 2 flops (rx_s); all decisions use rx_s; latency 2 clk.
//  Bit timer: counts 0..CLKS_PER_BIT-1; restarts on every state entry.
//  FSM:
//   - IDLE: rx_s=0 -> START
//   - START: at count CLKS_PER_BIT/2-1 (mid-bit), sample rx_s:
//     0 -> DATA (timer restart, bit index=0); 1 -> IDLE (glitch, no pulse)
//   - DATA: every CLKS_PER_BIT cycles, sample rx_s into shift reg at bit index (LSB first).
//     After index 4 -> PARITY.
//   - PARITY: sample once after CLKS_PER_BIT cycles -> STOP.
//   - STOP: sample after CLKS_PER_BIT cycles:
//     1 -> load entrada=data; erropar=(^{data,parity}==PARITY_ODD); pulse valido; -> IDLE
//     0 -> entrada/erropar unchanged; pulse erroquadro; -> WAIT_IDLE
//   - WAIT_IDLE: stay until rx_s=1 for one full CLKS_PER_BIT, then -> IDLE (break handling).
//  Timing: valido/erroquadro assert the clk after the stop sample, high exactly 1 cycle.
//   - entrada/erropar change on the same edge valido rises.
//  A parity-failing frame still updates entrada; erropar=0 tells the mapper to show the error glyph.
//  A new start bit is accepted on the cycle after returning to IDLE (back-to-back frames allowed).
//  valido and erroquadro are never high together.
//  ocupado=0 only in IDLE.
// TESTING (CLKS_PER_BIT=4, PARITY_ODD=0 unless noted)
//  1. Reset, rx idle 1 -> entrada=5'b11111, erropar=1, valido never pulses.
//  2. Frame data 5'b00101, parity 0, stop 1 -> valido 1 cycle, entrada=5'b00101, erropar=1.
//  3. Data 5'b00111, parity 0 (wrong) -> valido pulse, entrada=5'b00111, erropar=0.
//  4. Good frame 5'b00001, then frame 5'b01000 with stop 0 -> erroquadro pulse;
//     entrada stays 5'b00001; rx held 0 ten bits -> no valido until rx high 4 clk
//     and a new frame arrives.
//  5. 1-clk low glitch on rx in IDLE -> back to IDLE; no pulses; ocupado returns to 0.
//  6. rst asserted during DATA of frame 5'b10011 -> outputs at reset values; FSM=IDLE;
//     next full frame 5'b10011 decodes correctly.
//     Also repeat test 2 with PARITY_ODD=1, parity bit 1 -> erropar=1.

Source files
------------

// File: rtl/receptor_serial_simbolo.sv
// Serial symbol receiver: start, 5 data bits LSB first, parity, stop.
// Presents a held 5-bit symbol plus parity-ok flag to the 7-seg mapper.
module receptor_serial_simbolo #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [4:0] entrada,
    output logic       erropar,
    output logic       valido,
    output logic       erroquadro,
    output logic       ocupado
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t        state, state_d;
    logic [1:0]    sync;
    logic          rx_s;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    idx, idx_d;
    logic [4:0]    shift, shift_d;
    logic          par, par_d;
    logic [4:0]    entrada_d;
    logic          erropar_d;
    logic          valido_d;
    logic          erroquadro_d;
    logic          last;

    assign rx_s    = sync[1];
    assign last    = (cnt == LAST);
    assign ocupado = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync       <= 2'b11;
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shift      <= '0;
            par        <= 1'b0;
            entrada    <= 5'b11111;
            erropar    <= 1'b1;
            valido     <= 1'b0;
            erroquadro <= 1'b0;
        end else begin
            sync       <= {sync[0], rx};
            state      <= state_d;
            cnt        <= cnt_d;
            idx        <= idx_d;
            shift      <= shift_d;
            par        <= par_d;
            entrada    <= entrada_d;
            erropar    <= erropar_d;
            valido     <= valido_d;
            erroquadro <= erroquadro_d;
        end
    end

    always_comb begin
        state_d      = state;
        cnt_d        = cnt + 1'b1;
        idx_d        = idx;
        shift_d      = shift;
        par_d        = par;
        entrada_d    = entrada;
        erropar_d    = erropar;
        valido_d     = 1'b0;
        erroquadro_d = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt == HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (last) begin
                    cnt_d = '0;
                    // right shift so the first bit lands in bit 0
                    shift_d = {rx_s, shift[4:1]};
                    if (idx == 3'd4) begin
                        state_d = PARITY;
                    end else begin
                        idx_d = idx + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (last) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (last) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        entrada_d = shift;
                        erropar_d = ((^{shift, par}) == PARITY_ODD);
                        valido_d  = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        erroquadro_d = 1'b1;
                        state_d      = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                // line must stay idle a full bit time before rearming
                if (!rx_s) begin
                    cnt_d = '0;
                end else if (last) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_receptor_serial_simbolo.sv
// Directed bench for receptor_serial_simbolo, CLKS_PER_BIT=4.
// Even and odd parity instances share clk, rst and rx.
module tb_receptor_serial_simbolo;

    localparam int CPB = 4;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [4:0] entrada,    entrada_o;
    logic       erropar,    erropar_o;
    logic       valido,     valido_o;
    logic       erroquadro, erroquadro_o;
    logic       ocupado,    ocupado_o;

    int errors = 0;
    int checks = 0;
    int vcyc   = 0;
    int vocyc  = 0;
    int fcyc   = 0;
    int ocyc   = 0;
    int both   = 0;

    receptor_serial_simbolo #(
        .CLKS_PER_BIT(CPB),
        .PARITY_ODD  (1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .entrada   (entrada),
        .erropar   (erropar),
        .valido    (valido),
        .erroquadro(erroquadro),
        .ocupado   (ocupado)
    );

    receptor_serial_simbolo #(
        .CLKS_PER_BIT(CPB),
        .PARITY_ODD  (1'b1)
    ) dut_odd (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .entrada   (entrada_o),
        .erropar   (erropar_o),
        .valido    (valido_o),
        .erroquadro(erroquadro_o),
        .ocupado   (ocupado_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valido)               vcyc++;
        if (valido_o)             vocyc++;
        if (erroquadro)           fcyc++;
        if (ocupado)              ocyc++;
        if (valido && erroquadro) both++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [4:0] d, input logic p,
                              input logic s);
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(s);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx  = 1'b1;
        tick(3);
        checks++;
        if (entrada !== 5'b11111) begin
            errors++;
            $display("FAIL reset_entrada got=%b exp=11111", entrada);
        end
        checks++;
        if (erropar !== 1'b1 || valido !== 1'b0 || erroquadro !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b%b%b exp=100",
                     erropar, valido, erroquadro);
        end
        checks++;
        if (ocupado !== 1'b0) begin
            errors++;
            $display("FAIL reset_ocupado got=%b exp=0", ocupado);
        end
        rst = 1'b0;
        tick(20);
        checks++;
        if (vcyc !== 0 || ocupado !== 1'b0 || entrada !== 5'b11111) begin
            errors++;
            $display("FAIL idle_quiet vcyc=%0d ocup=%b ent=%b exp=0 0 11111",
                     vcyc, ocupado, entrada);
        end
    endtask

    task automatic test_good_frame;
        int v0;
        v0 = vcyc;
        send_frame(5'b00101, 1'b0, 1'b1);
        tick(12);
        checks++;
        if (vcyc - v0 !== 1) begin
            errors++;
            $display("FAIL good_valido cycles=%0d exp=1", vcyc - v0);
        end
        checks++;
        if (entrada !== 5'b00101 || erropar !== 1'b1) begin
            errors++;
            $display("FAIL good_data got=%b/%b exp=00101/1", entrada, erropar);
        end
        checks++;
        if (ocupado !== 1'b0) begin
            errors++;
            $display("FAIL good_ocupado got=%b exp=0", ocupado);
        end
    endtask

    task automatic test_parity_error;
        int v0;
        v0 = vcyc;
        send_frame(5'b00111, 1'b0, 1'b1);
        tick(12);
        checks++;
        if (vcyc - v0 !== 1) begin
            errors++;
            $display("FAIL par_valido cycles=%0d exp=1", vcyc - v0);
        end
        checks++;
        if (entrada !== 5'b00111 || erropar !== 1'b0) begin
            errors++;
            $display("FAIL par_data got=%b/%b exp=00111/0", entrada, erropar);
        end
    endtask

    task automatic test_framing;
        int v0;
        int f0;
        send_frame(5'b00001, 1'b1, 1'b1);
        tick(12);
        checks++;
        if (entrada !== 5'b00001 || erropar !== 1'b1) begin
            errors++;
            $display("FAIL frm_pre got=%b/%b exp=00001/1", entrada, erropar);
        end
        v0 = vcyc;
        f0 = fcyc;
        send_frame(5'b01000, 1'b1, 1'b0);
        tick(10 * CPB);
        checks++;
        if (fcyc - f0 !== 1) begin
            errors++;
            $display("FAIL frm_pulse cycles=%0d exp=1", fcyc - f0);
        end
        checks++;
        if (vcyc !== v0 || entrada !== 5'b00001 || erropar !== 1'b1) begin
            errors++;
            $display("FAIL frm_hold v=%0d ent=%b par=%b exp=%0d 00001 1",
                     vcyc, entrada, erropar, v0);
        end
        checks++;
        if (ocupado !== 1'b1) begin
            errors++;
            $display("FAIL frm_break_busy got=%b exp=1", ocupado);
        end
        rx = 1'b1;
        tick(2);
        checks++;
        if (ocupado !== 1'b1) begin
            errors++;
            $display("FAIL frm_early_idle got=%b exp=1", ocupado);
        end
        tick(10);
        checks++;
        if (ocupado !== 1'b0 || vcyc !== v0) begin
            errors++;
            $display("FAIL frm_rearm ocup=%b v=%0d exp=0 %0d",
                     ocupado, vcyc, v0);
        end
        send_frame(5'b00110, 1'b0, 1'b1);
        tick(12);
        checks++;
        if (vcyc - v0 !== 1 || entrada !== 5'b00110 || erropar !== 1'b1) begin
            errors++;
            $display("FAIL frm_next v=%0d ent=%b par=%b exp=1 00110 1",
                     vcyc - v0, entrada, erropar);
        end
    endtask

    task automatic test_glitch;
        int v0;
        int f0;
        int o0;
        tick(4);
        v0 = vcyc;
        f0 = fcyc;
        o0 = ocyc;
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(12);
        checks++;
        if (ocyc == o0) begin
            errors++;
            $display("FAIL glitch_start busy_cycles=%0d exp=>0", ocyc - o0);
        end
        checks++;
        if (ocupado !== 1'b0 || vcyc !== v0 || fcyc !== f0) begin
            errors++;
            $display("FAIL glitch_quiet ocup=%b dv=%0d df=%0d exp=0 0 0",
                     ocupado, vcyc - v0, fcyc - f0);
        end
    endtask

    task automatic test_reset_mid;
        int v0;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        checks++;
        if (ocupado !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy got=%b exp=1", ocupado);
        end
        rst = 1'b1;
        tick(1);
        rx = 1'b1;
        tick(2);
        rst = 1'b0;
        v0 = vcyc;
        tick(4 * CPB);
        checks++;
        if (entrada !== 5'b11111 || erropar !== 1'b1 || ocupado !== 1'b0
            || vcyc !== v0) begin
            errors++;
            $display("FAIL mid_reset ent=%b par=%b ocup=%b dv=%0d exp=11111 1 0 0",
                     entrada, erropar, ocupado, vcyc - v0);
        end
        send_frame(5'b10011, 1'b1, 1'b1);
        tick(12);
        checks++;
        if (vcyc - v0 !== 1 || entrada !== 5'b10011 || erropar !== 1'b1) begin
            errors++;
            $display("FAIL mid_next v=%0d ent=%b par=%b exp=1 10011 1",
                     vcyc - v0, entrada, erropar);
        end
    endtask

    task automatic test_odd_parity;
        int v0;
        v0 = vocyc;
        send_frame(5'b00101, 1'b1, 1'b1);
        tick(12);
        checks++;
        if (vocyc - v0 !== 1 || entrada_o !== 5'b00101 || erropar_o !== 1'b1) begin
            errors++;
            $display("FAIL odd_frame v=%0d ent=%b par=%b exp=1 00101 1",
                     vocyc - v0, entrada_o, erropar_o);
        end
        checks++;
        if (entrada !== 5'b00101 || erropar !== 1'b0) begin
            errors++;
            $display("FAIL odd_on_even ent=%b par=%b exp=00101 0",
                     entrada, erropar);
        end
    endtask

    task automatic test_back_to_back;
        int v0;
        v0 = vcyc;
        send_frame(5'b00011, 1'b0, 1'b1);
        send_frame(5'b11000, 1'b0, 1'b1);
        tick(12);
        checks++;
        if (vcyc - v0 !== 2) begin
            errors++;
            $display("FAIL b2b_count got=%0d exp=2", vcyc - v0);
        end
        checks++;
        if (entrada !== 5'b11000 || erropar !== 1'b1) begin
            errors++;
            $display("FAIL b2b_data got=%b/%b exp=11000/1", entrada, erropar);
        end
        checks++;
        if (both !== 0) begin
            errors++;
            $display("FAIL overlap cycles=%0d exp=0", both);
        end
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        test_reset();
        test_good_frame();
        test_parity_error();
        test_framing();
        test_glitch();
        test_reset_mid();
        test_odd_parity();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
